pipe_hazard_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage ARM-subset pipeline (IF/ID/EXE/MEM/WB).
- Produces the `freeze` for IF and the IF/ID register, the bubble insert for ID/EXE, the branch flushes, and a global freeze while the data-memory (SRAM) access is outstanding.
- Sits beside the stage modules. Consumes register-file indices from ID, destination/writeback info from EXE and MEM, `Branch_taken` from EXE, and the SRAM handshake.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/raw_hazard_detect.sv | 49 ++++
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller and the
// stage modules around it: controller states, register-index width and
// the instruction word loaded into a stage register on bubble or flush.
// Build option: FORWARDING_EN (consumed by raw_hazard_detect).
package pipe_ctrl_pkg;

    // Register-file index width (R0..R15)
    localparam int REG_IDX_W = 4;

    // MOV R0, R0 -- architectural no-op written by the stages on bubble/flush
    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

    // Controller states: normal issue, or waiting on an outstanding SRAM access
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/raw_hazard_detect.sv
// Combinational read-after-write detector comparing the ID-stage source
// registers against the destinations of the instructions in EXE and MEM.
// Build option: FORWARDING_EN -- when defined, only a load in EXE feeding
// the ID instruction stalls; everything else is covered by forwarding.
module raw_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 exe_wb_en,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_mem_read,
    input  logic                 mem_wb_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    output logic                 haz
);

    logic exe_match;
    logic mem_match;

    // Source-vs-destination comparisons; src2 only counts when it is read
    always_comb begin
        exe_match = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
        mem_match = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));
    end

`ifdef FORWARDING_EN
    // MEM results are forwarded, so only the MEM comparison goes unused here
    logic unused_mem;
    assign unused_mem = mem_match | mem_wb_en;

    // Load-use: the loaded value is not available until after MEM
    always_comb begin
        haz = id_valid && exe_wb_en && exe_mem_read && exe_match;
    end
`else
    // Without forwarding the load flag is irrelevant: any pending write stalls
    logic unused_load;
    assign unused_load = exe_mem_read;

    // Any in-flight writer of a source register stalls the ID instruction
    always_comb begin
        haz = id_valid && ((exe_wb_en && exe_match) || (mem_wb_en && mem_match));
    end
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing controller for the 5-stage pipeline. Generates the
// front-end freeze, ID/EXE bubble, branch flushes and the global freeze
// held while an SRAM access is outstanding, plus a sticky timeout flag
// and a saturating count of inserted hazard bubbles.
// Build option: FORWARDING_EN (selects the hazard rule in raw_hazard_detect).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 exe_wb_en,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_mem_read,
    input  logic                 mem_wb_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 freeze_front,
    output logic                 bubble_idexe,
    output logic                 flush_ifid,
    output logic                 flush_idexe,
    output logic                 freeze_all,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    // The RUN cycle that raises the request is already frozen, so MEM_WAIT
    // leaves when the counter would reach MEM_TIMEOUT-1: MEM_TIMEOUT frozen
    // cycles in total for one access.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              set_timeout;
    logic              freeze_raw;
    logic              haz;
    logic [CNT_W-1:0]  stall_q;

    raw_hazard_detect u_haz (
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_wb_en    (exe_wb_en),
        .exe_dest     (exe_dest),
        .exe_mem_read (exe_mem_read),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .haz          (haz)
    );

    // State register, SRAM wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Next state, wait-count update and the raw (pre-reset-gating) freeze
    always_comb begin
        state_next  = state;
        wait_next   = wait_cnt;
        set_timeout = 1'b0;
        freeze_raw  = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze_raw = 1'b1;
                    state_next = MEM_WAIT;
                    wait_next  = '0;
                end
            end
            MEM_WAIT: begin
                freeze_raw = 1'b1;
                if (mem_ready) begin
                    state_next = RUN;
                    wait_next  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next  = RUN;
                    wait_next   = '0;
                    set_timeout = 1'b1;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase
    end

    // Pipeline control outputs: freeze beats branch, branch beats hazard,
    // and everything is silenced while reset is asserted
    always_comb begin
        freeze_all   = rst_n && freeze_raw;
        freeze_front = 1'b0;
        bubble_idexe = 1'b0;
        flush_ifid   = 1'b0;
        flush_idexe  = 1'b0;
        if (rst_n && !freeze_raw) begin
            if (branch_taken) begin
                flush_ifid  = 1'b1;
                flush_idexe = 1'b1;
            end else if (haz) begin
                freeze_front = 1'b1;
                bubble_idexe = 1'b1;
            end
        end
    end

    // Saturating count of hazard bubbles actually inserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bubble_idexe && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver applies one input vector
// per cycle and pushes the reference model's expected outputs; a monitor
// pops and compares at the falling edge.
// Build option: FORWARDING_EN selects the matching reference hazard rule.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 64;
    localparam int CNT_W       = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [3:0]       id_src1 = '0;
    logic [3:0]       id_src2 = '0;
    logic             id_two_src = 1'b0;
    logic             exe_wb_en = 1'b0;
    logic [3:0]       exe_dest = '0;
    logic             exe_mem_read = 1'b0;
    logic             mem_wb_en = 1'b0;
    logic [3:0]       mem_dest = '0;
    logic             branch_taken = 1'b0;
    logic             mem_req = 1'b0;
    logic             mem_ready = 1'b0;
    logic             freeze_front;
    logic             bubble_idexe;
    logic             flush_ifid;
    logic             flush_idexe;
    logic             freeze_all;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_count;

    typedef struct packed {
        logic             ff;
        logic             bub;
        logic             fi;
        logic             fe;
        logic             fa;
        logic             terr;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: access in progress, frozen cycles so far in it,
    // sticky timeout, bubble total
    bit   m_wait   = 1'b0;
    int   m_frozen = 0;
    bit   m_terr   = 1'b0;
    int   m_cnt    = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_wb_en    (exe_wb_en),
        .exe_dest     (exe_dest),
        .exe_mem_read (exe_mem_read),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .freeze_front (freeze_front),
        .bubble_idexe (bubble_idexe),
        .flush_ifid   (flush_ifid),
        .flush_idexe  (flush_idexe),
        .freeze_all   (freeze_all),
        .timeout_err  (timeout_err),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Does the ID instruction have to wait for an in-flight result?
    function automatic bit refHazard(bit v, logic [3:0] s1, logic [3:0] s2, bit two,
                                     bit ewb, logic [3:0] ed, bit emr, bit mwb, logic [3:0] md);
        bit reads_e;
        bit reads_m;
        reads_e = (s1 == ed) || (two && (s2 == ed));
        reads_m = (s1 == md) || (two && (s2 == md));
`ifdef FORWARDING_EN
        return v && ewb && emr && reads_e;
`else
        return v && ((ewb && reads_e) || (mwb && reads_m));
`endif
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, advance the model
    task automatic applyStimulus(input bit a_rst_n, input bit a_v, input logic [3:0] a_s1,
                                 input logic [3:0] a_s2, input bit a_two, input bit a_ewb,
                                 input logic [3:0] a_ed, input bit a_emr, input bit a_mwb,
                                 input logic [3:0] a_md, input bit a_br, input bit a_req,
                                 input bit a_rdy);
        exp_t e;
        bit   fa;
        rst_n        = a_rst_n;
        id_valid     = a_v;
        id_src1      = a_s1;
        id_src2      = a_s2;
        id_two_src   = a_two;
        exe_wb_en    = a_ewb;
        exe_dest     = a_ed;
        exe_mem_read = a_emr;
        mem_wb_en    = a_mwb;
        mem_dest     = a_md;
        branch_taken = a_br;
        mem_req      = a_req;
        mem_ready    = a_rdy;
        e = '0;
        if (!a_rst_n) begin
            m_wait   = 1'b0;
            m_frozen = 0;
            m_terr   = 1'b0;
            m_cnt    = 0;
        end else begin
            fa     = m_wait || (a_req && !a_rdy);
            e.fa   = fa;
            e.terr = m_terr;
            e.cnt  = CNT_W'(m_cnt);
            if (!fa) begin
                if (a_br) begin
                    e.fi = 1'b1;
                    e.fe = 1'b1;
                end else if (refHazard(a_v, a_s1, a_s2, a_two, a_ewb, a_ed, a_emr, a_mwb, a_md)) begin
                    e.ff  = 1'b1;
                    e.bub = 1'b1;
                end
            end
            if (e.bub && m_cnt < CNT_MAX) m_cnt++;
            if (!m_wait) begin
                if (a_req && !a_rdy) begin
                    m_wait   = 1'b1;
                    m_frozen = 1;
                end
            end else begin
                m_frozen++;
                if (a_rdy) begin
                    m_wait = 1'b0;
                end else if (m_frozen == MEM_TIMEOUT) begin
                    m_wait = 1'b0;
                    m_terr = 1'b1;
                end
            end
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit br, input bit req, input bit rdy);
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, br, req, rdy);
    endtask

    task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        chk("freeze_front", CNT_W'(freeze_front), CNT_W'(e.ff));
        chk("bubble_idexe", CNT_W'(bubble_idexe), CNT_W'(e.bub));
        chk("flush_ifid",   CNT_W'(flush_ifid),   CNT_W'(e.fi));
        chk("flush_idexe",  CNT_W'(flush_idexe),  CNT_W'(e.fe));
        chk("freeze_all",   CNT_W'(freeze_all),   CNT_W'(e.fa));
        chk("timeout_err",  CNT_W'(timeout_err),  CNT_W'(e.terr));
        chk("stall_count",  stall_count,          e.cnt);
    endtask

    // Monitor: compare whatever the driver has queued, away from the clock edge
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) checkOutput(expq.pop_front());
        end
    end

    // Driver: directed scenarios, randomized traffic, saturation, mid-wait reset
    initial begin
        @(posedge clk);
        #1;
        $display("[TB] reset with active inputs");
        applyStimulus(1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b0, 1'b0);

        $display("[TB] load-use on R11 with zero-wait SRAM");
        applyStimulus(1'b1, 1'b1, 4'd11, 4'd0, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 4'd11, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);

        $display("[TB] ADD R3 in MEM, ID reads R3");
        applyStimulus(1'b1, 1'b1, 4'd1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);

        $display("[TB] branch together with hazard");
        applyStimulus(1'b1, 1'b1, 4'd7, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);

        $display("[TB] SRAM wait with branch held");
        for (int i = 0; i < 5; i++) idle(1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);

        $display("[TB] SRAM timeout");
        for (int i = 0; i < MEM_TIMEOUT; i++) idle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            bit req;
            bit rdy;
            req = m_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            applyStimulus(($urandom_range(0, 299) != 0), 1'($urandom), 4'($urandom_range(0, 3)),
                          4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                          4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                          4'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), req, rdy);
        end

        $display("[TB] bubble counter saturation");
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            applyStimulus(1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        idle(1'b0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of an SRAM wait");
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        idle(1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0);

        // Let the monitor drain the queue, but never wait forever
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        if (expq.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
